// File: rtl/ifetcher_pkg.sv
// Shared opcodes, defaults, FSM encoding and immediate decoders for the
// instruction fetcher.
package ifetcher_pkg;

    localparam int ICACHE_IDX_DEF = 6;
    localparam int BHT_IDX_DEF    = 8;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [6:0] LUIOP   = 7'b0110111;
    localparam logic [6:0] AUIPCOP = 7'b0010111;
    localparam logic [6:0] JALOP   = 7'b1101111;
    localparam logic [6:0] JALROP  = 7'b1100111;
    localparam logic [6:0] BROP    = 7'b1100011;

    typedef enum logic [1:0] {
        FETCH,
        MEM_WAIT,
        JALR_WAIT
    } state_e;

    function automatic logic [31:0] b_imm(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifetcher_if.sv
// Issue-stage, memory-controller and ROB signals of the fetcher; the
// master side is the fetcher itself.
interface ifetcher_if;
    logic        rdy;
    logic        ROB_full;
    logic        LSB_full;
    logic        IF_ins_sgn;
    logic [31:0] IF_ins;
    logic        IF_jump_flag;
    logic [31:0] IF_jump_pc;
    logic        MC_sgn;
    logic [31:0] MC_addr;
    logic        MC_done;
    logic [31:0] MC_ins;
    logic        ROB_clr;
    logic [31:0] ROB_newpc;
    logic        ROB_br_sgn;
    logic [31:0] ROB_br_pc;
    logic        ROB_br_taken;

    modport master (
        input  rdy, ROB_full, LSB_full, MC_done, MC_ins,
               ROB_clr, ROB_newpc, ROB_br_sgn, ROB_br_pc, ROB_br_taken,
        output IF_ins_sgn, IF_ins, IF_jump_flag, IF_jump_pc, MC_sgn, MC_addr
    );

    modport slave (
        output rdy, ROB_full, LSB_full, MC_done, MC_ins,
               ROB_clr, ROB_newpc, ROB_br_sgn, ROB_br_pc, ROB_br_taken,
        input  IF_ins_sgn, IF_ins, IF_jump_flag, IF_jump_pc, MC_sgn, MC_addr
    );
endinterface

// File: rtl/ifetcher_icache.sv
// Direct-mapped instruction cache, one word per line: combinational lookup
// on a word address and a single write port for memory refills.
module ifetcher_icache
    import ifetcher_pkg::*;
#(
    parameter int IDX = ICACHE_IDX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] rd_word,
    output logic        hit,
    output logic [31:0] rd_data,
    input  logic        we,
    input  logic [29:0] wr_word,
    input  logic [31:0] wr_data
);
    localparam int LINES = 1 << IDX;
    localparam int TAG_W = 30 - IDX;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [IDX-1:0] rd_idx, wr_idx;
    assign rd_idx = rd_word[IDX-1:0];
    assign wr_idx = wr_word[IDX-1:0];

    always_comb begin
        valid_d = valid_q;
        if (we) valid_d[wr_idx] = TRUE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    // NOTE: tag/data arrays have no reset; a cleared valid bit already hides whatever they hold.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[wr_idx]  <= wr_word[29:IDX];
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign hit     = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_word[29:IDX]);
    assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/ifetcher.sv
// Fetch unit: owns the fetch PC, a one-entry output register toward issue,
// the miss FSM to the memory controller and an inline 2-bit branch predictor.
module ifetcher
    import ifetcher_pkg::*;
#(
    parameter int          ICACHE_IDX = ICACHE_IDX_DEF,
    parameter int          BHT_IDX    = BHT_IDX_DEF,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input logic        clk,
    input logic        rst,
    ifetcher_if.master io
);
    localparam int BHT_N = 1 << BHT_IDX;

    state_e                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic                    out_valid_q, out_valid_d;
    logic [31:0]             ins_q, ins_d;
    logic                    jump_flag_q, jump_flag_d;
    logic [31:0]             jump_pc_q, jump_pc_d;
    logic                    mc_sgn_q, mc_sgn_d;
    logic [31:0]             mc_addr_q, mc_addr_d;
    logic                    discard_q, discard_d;
    logic [BHT_N-1:0][1:0]   bht_q, bht_d;

    logic                    ic_hit, ic_we;
    logic [31:0]             ic_data;
    logic                    consume, can_load;
    logic [BHT_IDX-1:0]      bht_rd_idx, bht_wr_idx;
    logic                    unused_br_bits;

    assign bht_rd_idx     = pc_q[BHT_IDX+1:2];
    assign bht_wr_idx     = io.ROB_br_pc[BHT_IDX+1:2];
    assign unused_br_bits = ^{io.ROB_br_pc[31:BHT_IDX+2], io.ROB_br_pc[1:0]};

    ifetcher_icache #(.IDX(ICACHE_IDX)) u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_word (pc_q[31:2]),
        .hit     (ic_hit),
        .rd_data (ic_data),
        .we      (ic_we && io.rdy),
        .wr_word (mc_addr_q[31:2]),
        .wr_data (io.MC_ins)
    );

    assign consume  = out_valid_q && !io.ROB_full && !io.LSB_full;
    assign can_load = !out_valid_q || consume;

    always_comb begin
        // NOTE: every _d is defaulted to its _q first so no path can infer a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = consume ? FALSE : out_valid_q;
        ins_d       = ins_q;
        jump_flag_d = jump_flag_q;
        jump_pc_d   = jump_pc_q;
        mc_sgn_d    = mc_sgn_q;
        mc_addr_d   = mc_addr_q;
        discard_d   = (io.MC_done && discard_q) ? FALSE : discard_q;
        bht_d       = bht_q;
        ic_we       = FALSE;

        unique case (state_q)
            FETCH: begin
                if (can_load && ic_hit) begin
                    out_valid_d = TRUE;
                    ins_d       = ic_data;
                    jump_flag_d = FALSE;
                    jump_pc_d   = pc_q + 32'd4;
                    pc_d        = pc_q + 32'd4;
                    unique case (ic_data[6:0])
                        AUIPCOP: jump_pc_d = pc_q;
                        JALOP: begin
                            jump_flag_d = TRUE;
                            pc_d        = pc_q + j_imm(ic_data);
                        end
                        BROP: begin
                            jump_pc_d = pc_q + b_imm(ic_data);
                            if (bht_q[bht_rd_idx][1]) begin
                                jump_flag_d = TRUE;
                                pc_d        = pc_q + b_imm(ic_data);
                            end
                        end
                        JALROP:  state_d = JALR_WAIT;
                        LUIOP:   ;
                        default: ;
                    endcase
                end else if (can_load && !discard_q) begin
                    // A flushed request is still in flight while discard_q is set.
                    mc_sgn_d  = TRUE;
                    mc_addr_d = {pc_q[31:2], 2'b00};
                    state_d   = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (io.MC_done) begin
                    ic_we    = TRUE;
                    mc_sgn_d = FALSE;
                    state_d  = FETCH;
                end
            end
            JALR_WAIT: ;
            default:   state_d = FETCH;
        endcase

        if (io.ROB_br_sgn) begin
            if (io.ROB_br_taken) begin
                if (bht_q[bht_wr_idx] != 2'b11) bht_d[bht_wr_idx] = bht_q[bht_wr_idx] + 2'b01;
            end else if (bht_q[bht_wr_idx] != 2'b00) begin
                bht_d[bht_wr_idx] = bht_q[bht_wr_idx] - 2'b01;
            end
        end

        // Redirect overrides everything above except the predictor update.
        if (io.ROB_clr) begin
            out_valid_d = FALSE;
            pc_d        = io.ROB_newpc;
            state_d     = FETCH;
            mc_sgn_d    = FALSE;
            ic_we       = FALSE;
            if (state_q == MEM_WAIT && !io.MC_done) discard_d = TRUE;
        end
    end

    // NOTE: state registers use non-blocking <= so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            out_valid_q <= FALSE;
            ins_q       <= '0;
            jump_flag_q <= FALSE;
            jump_pc_q   <= '0;
            mc_sgn_q    <= FALSE;
            mc_addr_q   <= '0;
            discard_q   <= FALSE;
            bht_q       <= {BHT_N{2'b01}};
        end else if (io.rdy) begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            ins_q       <= ins_d;
            jump_flag_q <= jump_flag_d;
            jump_pc_q   <= jump_pc_d;
            mc_sgn_q    <= mc_sgn_d;
            mc_addr_q   <= mc_addr_d;
            discard_q   <= discard_d;
            bht_q       <= bht_d;
        end
    end

    assign io.IF_ins_sgn   = out_valid_q;
    assign io.IF_ins       = ins_q;
    assign io.IF_jump_flag = jump_flag_q;
    assign io.IF_jump_pc   = jump_pc_q;
    assign io.MC_sgn       = mc_sgn_q;
    assign io.MC_addr      = mc_addr_q;

endmodule

// File: tb/tb_ifetcher.sv
// Scoreboard bench for ifetcher: expected issue words and memory requests are
// queued when stimulus is set up and compared as the DUT produces them.
module tb_ifetcher;
    import ifetcher_pkg::*;

    typedef struct {
        logic [31:0] ins;
        logic        flag;
        logic [31:0] jpc;
    } exp_t;

    logic clk;
    logic rst;
    ifetcher_if bus();

    ifetcher dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    logic [31:0] mc_q[$];
    logic [31:0] mem [256];
    int          mem_lat = 3;
    exp_t        mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_out(input logic [31:0] ins, input logic flag, input logic [31:0] jpc);
        exp_t e;
        e.ins  = ins;
        e.flag = flag;
        e.jpc  = jpc;
        sb.push_back(e);
    endtask

    // Straight-line program from 0 with a cold predictor: not-taken beq, JAL over 0x14, JALR stop.
    task automatic push_prog();
        push_out(32'h00500093, 1'b0, 32'h04);
        push_out(32'h00100113, 1'b0, 32'h08);
        push_out(32'hFE000EE3, 1'b0, 32'h04);
        push_out(32'h00000013, 1'b0, 32'h10);
        push_out(32'h0080006F, 1'b1, 32'h14);
        push_out(32'h00000013, 1'b0, 32'h1C);
        push_out(32'h00000013, 1'b0, 32'h20);
        push_out(32'h000080E7, 1'b0, 32'h24);
    endtask

    task automatic flush(input logic [31:0] newpc);
        bus.ROB_clr   = 1'b1;
        bus.ROB_newpc = newpc;
        step();
        bus.ROB_clr   = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!bus.IF_ins_sgn && n < budget) begin
            step();
            n++;
        end
        check(tag, {31'b0, bus.IF_ins_sgn}, 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check(tag, sb.size(), 32'd0);
    endtask

    // Issue-side monitor: every consumed word is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst && bus.rdy && bus.IF_ins_sgn && !bus.ROB_full && !bus.LSB_full) begin
            if (sb.size() > 0) mon_e = sb.pop_front();
            else               mon_e = '{ins: 32'hDEADDEAD, flag: 1'b0, jpc: 32'hDEADDEAD};
            check("out_ins",  bus.IF_ins,                   mon_e.ins);
            check("out_flag", {31'b0, bus.IF_jump_flag},    {31'b0, mon_e.flag});
            check("out_jpc",  bus.IF_jump_pc,               mon_e.jpc);
        end
    end

    // Memory controller model: checks each request address, answers after mem_lat cycles.
    initial begin
        logic [31:0] addr, exp_addr;
        bus.MC_done = 1'b0;
        bus.MC_ins  = '0;
        forever begin
            step();
            if (rst && bus.MC_sgn) begin
                addr     = bus.MC_addr;
                exp_addr = (mc_q.size() > 0) ? mc_q.pop_front() : 32'hDEADBEEF;
                check("mc_req", addr, exp_addr);
                repeat (mem_lat - 1) step();
                bus.MC_ins  = mem[addr[9:2]];
                bus.MC_done = 1'b1;
                step();
                bus.MC_done = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h00000013;
        mem[8'h00] = 32'h00500093;
        mem[8'h01] = 32'h00100113;
        mem[8'h02] = 32'hFE000EE3;
        mem[8'h04] = 32'h0080006F;
        mem[8'h08] = 32'h000080E7;
        mem[8'h0C] = 32'h03000093;
        mem[8'h10] = 32'h04000113;

        rst              = 1'b0;
        bus.rdy          = 1'b1;
        bus.ROB_full     = 1'b0;
        bus.LSB_full     = 1'b0;
        bus.ROB_clr      = 1'b0;
        bus.ROB_newpc    = '0;
        bus.ROB_br_sgn   = 1'b0;
        bus.ROB_br_pc    = '0;
        bus.ROB_br_taken = 1'b0;

        step();
        check("rst_ins_sgn", {31'b0, bus.IF_ins_sgn}, 32'd0);
        check("rst_ins",     bus.IF_ins,              32'd0);
        check("rst_jpc",     bus.IF_jump_pc,          32'd0);
        check("rst_mc_sgn",  {31'b0, bus.MC_sgn},     32'd0);
        check("rst_mc_addr", bus.MC_addr,             32'd0);

        // Cold start: every word misses once, in program order.
        foreach (mc_q[i]) mc_q.delete(i);
        mc_q = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C, 32'h20};
        push_prog();
        step();
        rst = 1'b1;
        wait_drain("cold_drain", 400);
        repeat (10) step();
        check("jalr_idle_sgn", {31'b0, bus.IF_ins_sgn}, 32'd0);
        check("jalr_idle_mc",  {31'b0, bus.MC_sgn},     32'd0);

        // Warm pass: all hits, one word per cycle with no bubble.
        push_prog();
        flush(32'h0);
        repeat (9) step();
        check("warm_one_per_cycle", sb.size(), 32'd0);

        // Back-pressure and global stall hold the output register.
        push_prog();
        flush(32'h0);
        repeat (2) step();
        bus.ROB_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rob_full_sgn", {31'b0, bus.IF_ins_sgn}, 32'd1);
            check("rob_full_ins", bus.IF_ins,              32'h00100113);
        end
        bus.ROB_full = 1'b0;
        bus.rdy      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rdy_hold_ins", bus.IF_ins, 32'h00100113);
        end
        bus.rdy = 1'b1;
        wait_drain("stall_drain", 50);

        // Train the pc 8 counter 01 -> 10 -> 11, then the beq loops back to 4.
        bus.ROB_full     = 1'b1;
        bus.ROB_br_sgn   = 1'b1;
        bus.ROB_br_pc    = 32'h8;
        bus.ROB_br_taken = 1'b1;
        repeat (2) step();
        bus.ROB_br_sgn   = 1'b0;
        push_out(32'hFE000EE3, 1'b1, 32'h04);
        push_out(32'h00100113, 1'b0, 32'h08);
        push_out(32'hFE000EE3, 1'b1, 32'h04);
        flush(32'h8);
        wait_valid("bht_valid", 20);
        bus.ROB_full = 1'b0;
        repeat (3) step();
        bus.ROB_full = 1'b1;
        check("bht_drain", sb.size(), 32'd0);
        step();
        check("bht_loop_ins", bus.IF_ins,     32'h00100113);
        check("bht_loop_jpc", bus.IF_jump_pc, 32'h08);

        // JALR stops fetch until the redirect.
        push_out(32'h000080E7, 1'b0, 32'h24);
        flush(32'h20);
        wait_valid("jalr_valid", 20);
        bus.ROB_full = 1'b0;
        step();
        bus.ROB_full = 1'b1;
        check("jalr_drain", sb.size(), 32'd0);
        repeat (5) step();
        check("jalr_stop_sgn", {31'b0, bus.IF_ins_sgn}, 32'd0);
        check("jalr_stop_mc",  {31'b0, bus.MC_sgn},     32'd0);
        mc_q.push_back(32'h100);
        flush(32'h100);
        wait_valid("redir_valid", 30);
        check("redir_ins",  bus.IF_ins,                32'h00000013);
        check("redir_jpc",  bus.IF_jump_pc,            32'h104);
        check("redir_flag", {31'b0, bus.IF_jump_flag}, 32'd0);

        // Flush during a miss: the stale reply is neither cached nor issued.
        mem_lat = 6;
        mc_q.push_back(32'h30);
        flush(32'h30);
        begin
            int n = 0;
            while (!bus.MC_sgn && n < 10) begin
                step();
                n++;
            end
        end
        check("miss30_req", bus.MC_addr, 32'h30);
        step();
        flush(32'h40);
        check("flush_drops_mc", {31'b0, bus.MC_sgn}, 32'd0);
        mc_q.push_back(32'h40);
        wait_valid("after_discard_valid", 40);
        check("after_discard_ins", bus.IF_ins,     32'h04000113);
        check("after_discard_jpc", bus.IF_jump_pc, 32'h44);

        mem_lat = 3;
        mc_q.push_back(32'h30);
        flush(32'h30);
        wait_valid("refetch30_valid", 30);
        check("refetch30_ins", bus.IF_ins, 32'h03000093);
        check("mc_all_served", mc_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
